karplus_i2s_tx: RTL and testbench

- Audio sink for the Karplus-Strong synthesiser's 16-bit `syn_guitar` sample stream.
- Buffers samples in a small FIFO and serialises them as a mono-duplicated I2S stream (BCLK / LRCLK / DACDAT) for the board's audio codec DAC.
- Sits between the synth core and the codec pins, on the same system clock as the Nios/Avalon fabric.
- Status (FIFO level, sticky underrun) is exposed for the Nios driver to poll.

---
 rtl/karplus_i2s_tx.sv | 152 +++++++++++++++
 tb/tb_karplus_i2s_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karplus_i2s_tx.sv
// karplus_i2s_tx: FIFO-buffered I2S transmitter that duplicates each mono synth sample onto both channels.
// Define KS_I2S_HOLD_LAST_EN to repeat the last popped sample on underrun instead of sending silence.
module karplus_i2s_tx #(
  parameter int CLK_DIV  = 4,
  parameter int FIFO_AW  = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                tx_en,
  input  logic                underrun_clr,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_dacdat,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underrun
);

  localparam int DEPTH   = 2 ** FIFO_AW;
  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int SLOT_W  = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0]  RIGHT_SLOT = SLOT_W'(SAMPLE_W);
  localparam logic [DIV_W-1:0]   DIV_TC     = DIV_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic                bclk_q, bclk_d, lrclk_q, lrclk_d;
  logic                dacdat_q, dacdat_d, underrun_q, underrun_d;
  logic                push, pop, div_tc, fall_evt, frame_start, fifo_empty;
  logic [SAMPLE_W-1:0] load_word;

  assign sample_ready = (level_q != FULL_LEVEL);

  always_comb begin
    fifo_empty  = (level_q == '0);
    push        = sample_valid && sample_ready;
    div_tc      = tx_en && (div_q == DIV_TC);
    fall_evt    = div_tc && bclk_q;
    frame_start = fall_evt && (slot_q == LAST_SLOT);
    pop         = frame_start && !fifo_empty;
  end

`ifdef KS_I2S_HOLD_LAST_EN
  logic [SAMPLE_W-1:0] last_q, last_d;

  always_comb begin
    last_d    = pop ? mem_q[rd_ptr_q] : last_q;
    load_word = last_d;
  end
`else
  assign load_word = pop ? mem_q[rd_ptr_q] : '0;
`endif

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    div_d      = div_q;
    slot_d     = slot_q;
    shift_d    = shift_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    dacdat_d   = dacdat_q;
    underrun_d = underrun_q;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set wins over a same-cycle clear so an underrun is never lost.
    if (frame_start && fifo_empty) underrun_d = 1'b1;
    else if (underrun_clr)         underrun_d = 1'b0;

    if (!tx_en) begin
      div_d    = '0;
      slot_d   = LAST_SLOT;
      shift_d  = '0;
      bclk_d   = 1'b0;
      lrclk_d  = 1'b0;
      dacdat_d = 1'b0;
    end else begin
      div_d = div_tc ? '0 : div_q + 1'b1;
      if (div_tc) bclk_d = ~bclk_q;
      if (fall_evt) begin
        // NOTE: blocking assignments inside always_comb let slot_d be reused below in the same pass.
        slot_d   = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        lrclk_d  = (slot_d >= RIGHT_SLOT);
        // The MSB leaving here lags LRCLK by one slot, which yields the I2S one-bit delay.
        dacdat_d = shift_q[FRAME_W-1];
        shift_d  = frame_start ? {load_word, load_word} : {shift_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset restores every control flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_q      <= '0;
      slot_q     <= LAST_SLOT;
      shift_q    <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
`ifdef KS_I2S_HOLD_LAST_EN
      last_q     <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      div_q      <= div_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
`ifdef KS_I2S_HOLD_LAST_EN
      last_q     <= last_d;
`endif
    end
  end

  // NOTE: FIFO storage is deliberately not reset; clearing the pointers and level discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_dacdat = dacdat_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_karplus_i2s_tx.sv
// Directed bench for karplus_i2s_tx at CLK_DIV=2: frame format, FIFO fill/drain, underrun, reset and tx_en drop.
module tb_karplus_i2s_tx;
  localparam int CLK_DIV  = 2;
  localparam int FIFO_AW  = 3;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                sample_ready;
  logic                tx_en = 1'b0;
  logic                underrun_clr = 1'b0;
  logic                i2s_bclk, i2s_lrclk, i2s_dacdat;
  logic [FIFO_AW:0]    fifo_level;
  logic                underrun;

  always #5 clk = ~clk;

  karplus_i2s_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .SAMPLE_W(SAMPLE_W)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx_en(tx_en), .underrun_clr(underrun_clr),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_dacdat(i2s_dacdat),
    .fifo_level(fifo_level), .underrun(underrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic [3:0]  exp_level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic next_fall(output bit got);
    logic prev;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      prev = i2s_bclk;
      tick();
      if (prev === 1'b1 && i2s_bclk === 1'b0) got = 1'b1;
    end
  endtask

  task automatic skip_falls(input int n);
    bit got;
    for (int i = 0; i < n; i++) begin
      next_fall(got);
      if (!got) begin
        check("skip fall timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  function automatic logic [31:0] exp_dd(input logic [15:0] w, input logic k0);
    logic [31:0] r;
    r[0] = k0;
    for (int k = 1; k <= 16; k++) r[k] = w[16-k];
    for (int k = 17; k <= 31; k++) r[k] = w[32-k];
    return r;
  endfunction

  // Captures slots 0..31 of one frame; the caller guarantees the next BCLK fall is a frame start.
  task automatic capture(input string tag, input logic [15:0] w, input logic k0, input bit chk_k0,
                         input logic [3:0] lvl, output int t0);
    logic [31:0] lr, dd, ed;
    logic [3:0]  lvl_act;
    bit got;
    lr = '0; dd = '0; lvl_act = '0; t0 = 0;
    for (int k = 0; k < 32; k++) begin
      next_fall(got);
      if (!got) begin
        check($sformatf("%s fall timeout", tag), 32'd0, 32'd1);
        break;
      end
      lr[k] = i2s_lrclk;
      dd[k] = i2s_dacdat;
      if (k == 0) begin
        t0      = cyc;
        lvl_act = fifo_level;
      end
    end
    ed = exp_dd(w, k0);
    if (!chk_k0) begin
      dd[0] = 1'b0;
      ed[0] = 1'b0;
    end
    check($sformatf("%s lrclk", tag), lr, 32'hFFFF_0000);
    check($sformatf("%s dacdat", tag), dd, ed);
    check($sformatf("%s level", tag), 32'(lvl_act), 32'(lvl));
  endtask

  task automatic push(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    tx_en        = 1'b0;
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    sample_in    = '0;
    tick();
    check($sformatf("%s rst outs", tag), 32'({i2s_bclk, i2s_lrclk, i2s_dacdat, underrun, sample_ready}), 32'b00001);
    check($sformatf("%s rst level", tag), 32'(fifo_level), 32'd0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [10];
    int ta, tb, tdummy;
    logic [15:0] hold_w;

    vecs = '{
      '{1'b1, 16'h1000, 1'b1, 4'd0}, '{1'b1, 16'h1001, 1'b1, 4'd1},
      '{1'b1, 16'h1002, 1'b1, 4'd2}, '{1'b1, 16'h1003, 1'b1, 4'd3},
      '{1'b1, 16'h1004, 1'b1, 4'd4}, '{1'b1, 16'h1005, 1'b1, 4'd5},
      '{1'b1, 16'h1006, 1'b1, 4'd6}, '{1'b1, 16'h1007, 1'b1, 4'd7},
      '{1'b1, 16'h1008, 1'b0, 4'd8}, '{1'b0, 16'h0000, 1'b0, 4'd8}
    };

    // Single sample 0x8001: frame format, period, then an underrun frame.
    do_reset("t1");
    push(16'h8001);
    tx_en = 1'b1;
    capture("t1 f0", 16'h8001, 1'b0, 1'b1, 4'd0, ta);
    check("t1 underrun after f0", 32'(underrun), 32'd0);
`ifdef KS_I2S_HOLD_LAST_EN
    hold_w = 16'h8001;
`else
    hold_w = 16'h0000;
`endif
    capture("t1 f1", hold_w, 1'b1, 1'b1, 4'd0, tb);
    check("t1 period", 32'(tb - ta), 32'd128);
    check("t1 underrun after f1", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t1 underrun cleared", 32'(underrun), 32'd0);
    tx_en = 1'b0;

    // Table-driven fill with tx disabled, then drain one entry per frame.
    do_reset("t2");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2 v%0d ready", i), 32'(sample_ready), 32'(vecs[i].exp_ready));
      check($sformatf("t2 v%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
      sample_valid = vecs[i].valid;
      sample_in    = vecs[i].data;
      tick();
    end
    sample_valid = 1'b0;
    tx_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      capture($sformatf("t2 f%0d", f), 16'(16'h1000 + f), (f == 0) ? 1'b0 : 1'(f - 1), 1'b1,
              4'(7 - f), tb);
      if (f == 1) check("t2 period", 32'(tb - ta), 32'd128);
      ta = tb;
    end
`ifdef KS_I2S_HOLD_LAST_EN
    hold_w = 16'h1007;
`else
    hold_w = 16'h0000;
`endif
    capture("t2 f8", hold_w, 1'b1, 1'b1, 4'd0, tdummy);
    check("t2 underrun", 32'(underrun), 32'd1);
    tx_en = 1'b0;

    // Empty start, clear with a same-cycle push, then optional hold-last frame.
    do_reset("t3");
    tx_en = 1'b1;
    capture("t3 f0", 16'h0000, 1'b0, 1'b1, 4'd0, tdummy);
    check("t3 underrun f0", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    tick();
    underrun_clr = 1'b0;
    sample_valid = 1'b0;
    check("t3 underrun cleared", 32'(underrun), 32'd0);
    check("t3 level after push", 32'(fifo_level), 32'd1);
    capture("t3 f1", 16'h1234, 1'b0, 1'b1, 4'd0, tdummy);
    check("t3 underrun f1", 32'(underrun), 32'd0);
`ifdef KS_I2S_HOLD_LAST_EN
    hold_w = 16'h1234;
`else
    hold_w = 16'h0000;
`endif
    capture("t3 f2", hold_w, 1'b0, 1'b1, 4'd0, tdummy);
    check("t3 underrun f2", 32'(underrun), 32'd1);
    tx_en = 1'b0;

    // Push and underrun_clr exactly on the first frame-start cycle with an empty FIFO.
    do_reset("t4");
    tx_en = 1'b1;
    tick(); tick(); tick();
    sample_in    = 16'hBEEF;
    sample_valid = 1'b1;
    underrun_clr = 1'b1;
    tick();
    sample_valid = 1'b0;
    underrun_clr = 1'b0;
    check("t4 underrun set wins", 32'(underrun), 32'd1);
    check("t4 level kept", 32'(fifo_level), 32'd1);
    skip_falls(31);
    capture("t4 f1", 16'hBEEF, 1'b0, 1'b1, 4'd0, tdummy);
    tx_en = 1'b0;

    // Asynchronous reset in the middle of slot 10.
    do_reset("t5");
    push(16'hFFFF);
    push(16'h7777);
    tx_en = 1'b1;
    skip_falls(11);
    tick(); tick();
    check("t5 pre bclk", 32'(i2s_bclk), 32'd1);
    check("t5 pre dacdat", 32'(i2s_dacdat), 32'd1);
    check("t5 pre level", 32'(fifo_level), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5 async outs", 32'({i2s_bclk, i2s_lrclk, i2s_dacdat, underrun, sample_ready}), 32'b00001);
    check("t5 async level", 32'(fifo_level), 32'd0);
    tx_en = 1'b0;
    tick();
    reset = 1'b0;
    push(16'h5A5A);
    tx_en = 1'b1;
    capture("t5 f0", 16'h5A5A, 1'b0, 1'b1, 4'd0, tdummy);
    check("t5 underrun", 32'(underrun), 32'd0);
    tx_en = 1'b0;

    // tx_en dropped at slot 20 with three entries queued.
    do_reset("t6");
    push(16'hFFFF);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    tx_en = 1'b1;
    skip_falls(21);
    check("t6 slot20 lrclk", 32'(i2s_lrclk), 32'd1);
    check("t6 slot20 level", 32'(fifo_level), 32'd3);
    tick(); tick();
    check("t6 pre bclk", 32'(i2s_bclk), 32'd1);
    check("t6 pre dacdat", 32'(i2s_dacdat), 32'd1);
    tx_en = 1'b0;
    tick();
    check("t6 off outs", 32'({i2s_bclk, i2s_lrclk, i2s_dacdat}), 32'b000);
    check("t6 off level", 32'(fifo_level), 32'd3);
    for (int i = 0; i < 10; i++) tick();
    push(16'h4444);
    check("t6 push while off", 32'(fifo_level), 32'd4);
    tx_en = 1'b1;
    capture("t6 f1", 16'h1111, 1'b0, 1'b0, 4'd3, tdummy);
    capture("t6 f2", 16'h2222, 1'b1, 1'b1, 4'd2, tdummy);
    tx_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
